// File: rtl/ysyx_22041207_rd_arbiter.sv
// Read arbiter sharing one simple-bus read slave between MEM and IF.
// MEM has fixed priority, with a streak limit so IF cannot starve.
// A grant covers one whole transaction: the address phase, then the data phase.
// A watchdog abandons a transaction that stalls for too long.
module ysyx_22041207_rd_arbiter #(
    parameter int RW_DATA_WIDTH  = 64,
    parameter int RW_ADDR_WIDTH  = 64,
    parameter int MEM_STREAK_MAX = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     mem_r_valid_i,
    output logic                     mem_r_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] mem_r_addr_i,
    input  logic [7:0]               mem_r_size_i,
    output logic [RW_DATA_WIDTH-1:0] mem_data_read_o,
    output logic                     mem_r_data_valid,
    input  logic                     mem_r_data_ready,

    input  logic                     if_r_valid_i,
    output logic                     if_r_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] if_r_addr_i,
    input  logic [7:0]               if_r_size_i,
    output logic [RW_DATA_WIDTH-1:0] if_data_read_o,
    output logic                     if_r_data_valid,
    input  logic                     if_r_data_ready,

    output logic                     s_r_valid_i,
    input  logic                     s_r_ready_o,
    output logic [RW_ADDR_WIDTH-1:0] s_r_addr_i,
    output logic [7:0]               s_r_size_i,
    input  logic [RW_DATA_WIDTH-1:0] s_data_read_o,
    input  logic                     s_r_data_valid,
    output logic                     s_r_data_ready,

    output logic                     grant_mem_o,
    output logic                     grant_if_o,
    output logic                     timeout_o
);

    localparam logic [1:0]  IDLE = 2'd0;
    localparam logic [1:0]  ADDR = 2'd1;
    localparam logic [1:0]  DATA = 2'd2;

    localparam logic [3:0]  STREAK_MAX = 4'(MEM_STREAK_MAX);
    localparam bit          WD_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST    = 16'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic                     valid;
        logic [RW_ADDR_WIDTH-1:0] addr;
        logic [7:0]               size;
        logic                     data_ready;
    } rd_req_t;

    logic [1:0]  state;
    logic        owner;      // 0: MEM, 1: IF
    logic [3:0]  streak;
    logic [15:0] wd_cnt;
    logic        gnt_mem;
    logic        gnt_if;
    logic        timeout_q;

    rd_req_t mem_req, if_req, own_req;
    logic    in_addr, in_data;
    logic    addr_hs, data_hs, withdraw, wd_expire;
    logic    pick_if, any_req;

    assign mem_req  = '{valid: mem_r_valid_i, addr: mem_r_addr_i,
                        size: mem_r_size_i, data_ready: mem_r_data_ready};
    assign if_req   = '{valid: if_r_valid_i, addr: if_r_addr_i,
                        size: if_r_size_i, data_ready: if_r_data_ready};
    assign own_req  = owner ? if_req : mem_req;

    assign in_addr  = (state == ADDR);
    assign in_data  = (state == DATA);

    assign addr_hs  = in_addr & own_req.valid & s_r_ready_o;
    assign data_hs  = in_data & s_r_data_valid & own_req.data_ready;
    assign withdraw = in_addr & ~own_req.valid;
    // Completion in the expiry cycle takes precedence over the timeout.
    assign wd_expire = WD_EN & (in_addr | in_data) & (wd_cnt == WD_LAST) & ~data_hs;

    // IF wins only when alone, or when MEM has used up its streak.
    assign any_req  = mem_r_valid_i | if_r_valid_i;
    assign pick_if  = if_r_valid_i & (~mem_r_valid_i | (streak == STREAK_MAX));

    // Route the owner's handshakes to the slave and the slave's back to the owner.
    always_comb begin
        s_r_valid_i      = in_addr & own_req.valid;
        s_r_addr_i       = in_addr ? own_req.addr : '0;
        s_r_size_i       = in_addr ? own_req.size : 8'd0;
        s_r_data_ready   = in_data & own_req.data_ready;
        mem_r_ready_o    = in_addr & ~owner & s_r_ready_o;
        if_r_ready_o     = in_addr &  owner & s_r_ready_o;
        mem_r_data_valid = in_data & ~owner & s_r_data_valid;
        if_r_data_valid  = in_data &  owner & s_r_data_valid;
        mem_data_read_o  = s_data_read_o;
        if_data_read_o   = s_data_read_o;
    end

    assign grant_mem_o = gnt_mem;
    assign grant_if_o  = gnt_if;
    assign timeout_o   = timeout_q;

    // Arbitration, transaction phase tracking, streak and watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            streak    <= 4'd0;
            wd_cnt    <= 16'd0;
            gnt_mem   <= 1'b0;
            gnt_if    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_expire;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= ADDR;
                        owner   <= pick_if;
                        gnt_mem <= ~pick_if;
                        gnt_if  <= pick_if;
                        wd_cnt  <= 16'd0;
                        if (pick_if || !if_r_valid_i)
                            streak <= 4'd0;
                        else if (streak < STREAK_MAX)
                            streak <= streak + 4'd1;
                    end
                end
                ADDR, DATA: begin
                    wd_cnt <= wd_cnt + 16'd1;
                    if (wd_expire || data_hs || withdraw) begin
                        state   <= IDLE;
                        gnt_mem <= 1'b0;
                        gnt_if  <= 1'b0;
                    end else if (addr_hs) begin
                        state <= DATA;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_mem <= 1'b0;
                    gnt_if  <= 1'b0;
                end
            endcase
        end
    end

endmodule
